// File: rtl/pixel_frame_store_if.sv
// Signal bundle between game logic (master) and pixel_frame_store (slave):
// plot strokes, colour read-back and the full-frame clear request.
interface pixel_frame_store_if;
    logic       plot;
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] colour;
    logic       rd_req;
    logic [7:0] rd_x;
    logic [7:0] rd_y;
    logic       rd_ready;
    logic       rd_valid;
    logic [2:0] rd_colour;
    logic       clear_req;
    logic [2:0] clear_colour;
    logic       busy;
    logic       fifo_empty;
    logic       overflow;
    logic [7:0] clip_count;

    modport master (
        output plot, x, y, colour, rd_req, rd_x, rd_y, clear_req, clear_colour,
        input  rd_ready, rd_valid, rd_colour, busy, fifo_empty, overflow, clip_count
    );

    modport slave (
        input  plot, x, y, colour, rd_req, rd_x, rd_y, clear_req, clear_colour,
        output rd_ready, rd_valid, rd_colour, busy, fifo_empty, overflow, clip_count
    );
endinterface

// File: rtl/pixel_frame_store.sv
// Plot FIFO + 160x120x3 frame memory with a colour read port and a full-frame clear engine.
// Optional feature macro PIXEL_CLIP_EN: drop out-of-range plots and count them in clip_count.
module pixel_frame_store #(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               resetn,
    pixel_frame_store_if.slave bus
);
    localparam int ADDR_W    = 15;
    localparam int MEM_WORDS = 1 << ADDR_W;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);

    typedef enum logic {S_RUN, S_CLEAR} state_e;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [2:0] colour;
    } pixel_t;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] px, input logic [7:0] py);
        return ADDR_W'(int'(py) * WIDTH + int'(px));
    endfunction

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [2:0]        clr_colour_q, clr_colour_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic              overflow_q, overflow_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_oob_q, rd_oob_d;
    logic              rd_valid_q, rd_valid_d;
    logic [2:0]        rd_colour_q, rd_colour_d;

    pixel_t            fifo_mem  [FIFO_DEPTH];
    logic [2:0]        frame_mem [MEM_WORDS];

    logic              busy, rd_ready, fifo_empty, fifo_full;
    logic              plot_ok, rd_in_frame, push, pop, rd_accept;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [2:0]        mem_wdata;
    pixel_t            head;

`ifdef PIXEL_CLIP_EN
    function automatic logic in_frame(input logic [7:0] px, input logic [7:0] py);
        return (int'(px) < WIDTH) && (int'(py) < HEIGHT);
    endfunction

    logic [7:0] clip_count_q, clip_count_d;

    assign plot_ok     = bus.plot && in_frame(bus.x, bus.y);
    assign rd_in_frame = in_frame(bus.rd_x, bus.rd_y);

    always_comb begin
        clip_count_d = clip_count_q;
        if (bus.plot && !in_frame(bus.x, bus.y) && clip_count_q != 8'hFF)
            clip_count_d = clip_count_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) clip_count_q <= '0;
        else         clip_count_q <= clip_count_d;
    end

    assign bus.clip_count = clip_count_q;
`else
    assign plot_ok        = bus.plot;
    assign rd_in_frame    = 1'b1;
    assign bus.clip_count = '0;
`endif

    // FSM: state register
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) state_q <= S_RUN;
        else         state_q <= state_d;
    end

    // FSM: next state
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:   if (bus.clear_req)          state_d = S_CLEAR;
            S_CLEAR: if (clr_cnt_q == LAST_ADDR) state_d = S_RUN;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = 1'b0;
        rd_ready = 1'b0;
        unique case (state_q)
            S_RUN:   rd_ready = 1'b1;
            S_CLEAR: busy     = 1'b1;
        endcase
    end

    always_comb begin
        clr_cnt_d    = clr_cnt_q;
        clr_colour_d = clr_colour_q;
        if (state_q == S_RUN && bus.clear_req) begin
            clr_cnt_d    = '0;
            clr_colour_d = bus.clear_colour;
        end else if (state_q == S_CLEAR) begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];

    // A pending read owns the memory this cycle, so the pop slips; clears never drain.
    assign pop  = !fifo_empty && (state_q == S_RUN) && !rd_pend_q;
    assign push = plot_ok && (!fifo_full || pop);

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = overflow_q || (plot_ok && !push);
    end

    assign mem_we    = resetn && (busy || pop);
    assign mem_waddr = busy ? clr_cnt_q    : pix_addr(head.x, head.y);
    assign mem_wdata = busy ? clr_colour_q : head.colour;

    // The read port is separate from the write port so a read accepted alongside
    // clear_req still finishes on time while the first fill word is written.
    assign rd_accept = bus.rd_req && rd_ready;

    always_comb begin
        rd_pend_d   = rd_accept;
        rd_addr_d   = rd_accept ? pix_addr(bus.rd_x, bus.rd_y) : rd_addr_q;
        rd_oob_d    = rd_accept ? !rd_in_frame : rd_oob_q;
        rd_valid_d  = rd_pend_q;
        rd_colour_d = rd_colour_q;
        if (rd_pend_q)
            rd_colour_d = rd_oob_q ? 3'b000 : frame_mem[rd_addr_q];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            clr_cnt_q    <= '0;
            clr_colour_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            overflow_q   <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_addr_q    <= '0;
            rd_oob_q     <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_colour_q  <= '0;
        end else begin
            clr_cnt_q    <= clr_cnt_d;
            clr_colour_q <= clr_colour_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            overflow_q   <= overflow_d;
            rd_pend_q    <= rd_pend_d;
            rd_addr_q    <= rd_addr_d;
            rd_oob_q     <= rd_oob_d;
            rd_valid_q   <= rd_valid_d;
            rd_colour_q  <= rd_colour_d;
        end
    end

    // NOTE: storage arrays have no reset; the pointers carry FIFO validity and the frame must survive reset.
    always_ff @(posedge clk) begin
        if (push)   fifo_mem[wr_ptr_q[PTR_W-1:0]] <= '{x: bus.x, y: bus.y, colour: bus.colour};
        if (mem_we) frame_mem[mem_waddr]          <= mem_wdata;
    end

    assign bus.busy       = busy;
    assign bus.rd_ready   = rd_ready;
    assign bus.fifo_empty = fifo_empty;
    assign bus.overflow   = overflow_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_colour  = rd_colour_q;
endmodule
